pipelined_shift_unit: RTL and testbench

Parametrised, pipelined shift unit for the RV32I datapath and future wider variants. One block covers logical left, logical right and arithmetic right shifts, plus an optional rotate-right. It uses a logarithmic stage per shift-amount bit, with one register per stage and a valid/ready handshake on both sides. It sits between the execute-stage operand mux and the writeback result mux. Multi-cycle shifts do not stall the ALU path, and one shift can be accepted per cycle.

---
 rtl/pipelined_shift_unit.sv | 124 ++++++++++++
 tb/tb_pipelined_shift_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shift_unit.sv
// Logarithmic pipelined shifter: SLL/SRL/SRA, and rotate-right on op 11 when
// SHIFT_UNIT_ROTATE_EN is defined (otherwise op 11 behaves as SRL).
module pipelined_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic [WIDTH-1:0]   data_q   [SHAMT_W];
  logic [WIDTH-1:0]   data_d   [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_d  [SHAMT_W];
  logic [1:0]         op_q     [SHAMT_W];
  logic [1:0]         op_d     [SHAMT_W];
  logic [TAG_W-1:0]   tag_q    [SHAMT_W];
  logic [TAG_W-1:0]   tag_d    [SHAMT_W];
  logic [SHAMT_W-1:0] valid_q;
  logic [SHAMT_W-1:0] valid_d;
  logic [SHAMT_W-1:0] ready;
  logic               ready_acc;

  logic [WIDTH-1:0]   src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
  logic [1:0]         src_op    [SHAMT_W];
  logic [TAG_W-1:0]   src_tag   [SHAMT_W];
  logic [SHAMT_W-1:0] src_valid;

  // Arithmetic shifts keep the MSB in place, so each stage's MSB is still the original sign.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] op, input int amt);
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = d << amt;
      2'b10:   res = WIDTH'($signed(d) >>> amt);
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11:   res = (d >> amt) | (d << (WIDTH - amt));
`endif
      default: res = d >> amt;
    endcase
    return res;
  endfunction

  always_comb begin
    ready     = '0;
    ready_acc = out_ready;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      ready_acc = !valid_q[k] || ready_acc;
      ready[k]  = ready_acc;
    end

    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    src_tag[0]   = in_tag;
    for (int k = 1; k < SHAMT_W; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_op[k]    = op_q[k-1];
      src_tag[k]   = tag_q[k-1];
    end

    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (ready[k]) valid_d[k] = src_valid[k];
      // Payload only moves with a real transfer, so idle inputs never disturb state.
      if (ready[k] && src_valid[k]) begin
        data_d[k]  = src_shamt[k][k] ? shift_step(src_data[k], src_op[k], 1 << k)
                                     : src_data[k];
        shamt_d[k] = src_shamt[k];
        op_d[k]    = src_op[k];
        tag_d[k]   = src_tag[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        op_q[k]    <= op_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

  // The final stage's shamt and op have no downstream consumer.
  logic unused_tail;
  assign unused_tail = ^{shamt_q[SHAMT_W-1], op_q[SHAMT_W-1]};

  assign in_ready  = ready[0];
  assign out_valid = valid_q[SHAMT_W-1];
  assign out_data  = data_q[SHAMT_W-1];
  assign out_tag   = tag_q[SHAMT_W-1];

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench for pipelined_shift_unit (WIDTH=32): directed vectors,
// stall/ordering, randomized traffic against a reference model, and mid-flight reset.
module tb_pipelined_shift_unit;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic [4:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [4:0]    out_tag;

  int assertions = 0;
  int failures   = 0;

  pipelined_shift_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shifter built from wide concatenations rather than staged shifts
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int sh,
                                             input logic [1:0] op);
    logic [2*W-1:0] wide;
    case (op)
      2'b00: return a << sh;
      2'b01: return a >> sh;
      2'b10: begin
        wide = {{W{a[W-1]}}, a} >> sh;
        return wide[W-1:0];
      end
      default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
        wide = {a, a} >> sh;
        return wide[W-1:0];
`else
        return a >> sh;
`endif
      end
    endcase
  endfunction

  // Issue one operation into an empty pipeline and wait (bounded) for its result
  task automatic issue_and_wait(input logic [W-1:0] d, input logic [SW-1:0] s,
                                input logic [1:0] o, input logic [4:0] t,
                                output logic [W-1:0] res, output logic [4:0] rtag,
                                output int lat);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = s;
    in_op     = o;
    in_tag    = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = out_data;
    rtag = out_tag;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    assertions++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid actual=%b required=0", out_valid); end
    assertions++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready actual=%b required=1", in_ready); end
    assertions++;
    if (out_data !== 32'h0 || out_tag !== 5'h0) begin
      failures++; $display("[TB] FAIL reset_out_fields actual=%h/%h required=0/0", out_data, out_tag);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0]  vd [10];
    logic [SW-1:0] vs [10];
    logic [1:0]    vo [10];
    logic [W-1:0]  ve [10];
    logic [W-1:0]  res;
    logic [4:0]    rtag;
    int            lat;
    vd[0] = 32'h80000000; vs[0] = 5'd31; vo[0] = 2'b10; ve[0] = 32'hFFFFFFFF;
    vd[1] = 32'h80000000; vs[1] = 5'd31; vo[1] = 2'b01; ve[1] = 32'h00000001;
    vd[2] = 32'h00000001; vs[2] = 5'd31; vo[2] = 2'b00; ve[2] = 32'h80000000;
    vd[3] = 32'h7FFFFFF0; vs[3] = 5'd4;  vo[3] = 2'b10; ve[3] = 32'h07FFFFFF;
    vd[4] = 32'hDEADBEEF; vs[4] = 5'd0;  vo[4] = 2'b00; ve[4] = 32'hDEADBEEF;
    vd[5] = 32'hDEADBEEF; vs[5] = 5'd0;  vo[5] = 2'b01; ve[5] = 32'hDEADBEEF;
    vd[6] = 32'hDEADBEEF; vs[6] = 5'd0;  vo[6] = 2'b10; ve[6] = 32'hDEADBEEF;
    vd[7] = 32'hDEADBEEF; vs[7] = 5'd0;  vo[7] = 2'b11; ve[7] = 32'hDEADBEEF;
`ifdef SHIFT_UNIT_ROTATE_EN
    vd[8] = 32'h00000001; vs[8] = 5'd1;  vo[8] = 2'b11; ve[8] = 32'h80000000;
    vd[9] = 32'h000000F1; vs[9] = 5'd4;  vo[9] = 2'b11; ve[9] = 32'h1000000F;
`else
    vd[8] = 32'h00000001; vs[8] = 5'd1;  vo[8] = 2'b11; ve[8] = 32'h00000000;
    vd[9] = 32'h000000F1; vs[9] = 5'd4;  vo[9] = 2'b11; ve[9] = 32'h0000000F;
`endif
    for (int i = 0; i < 10; i++) begin
      issue_and_wait(vd[i], vs[i], vo[i], 5'h1A, res, rtag, lat);
      assertions++;
      if (lat !== SW) begin failures++; $display("[TB] FAIL latency_%0d actual=%0d required=%0d", i, lat, SW); end
      assertions++;
      if (res !== ve[i]) begin failures++; $display("[TB] FAIL data_%0d actual=%h required=%h", i, res, ve[i]); end
      assertions++;
      if (rtag !== 5'h1A) begin failures++; $display("[TB] FAIL tag_%0d actual=%h required=1a", i, rtag); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] exp_q [$];
    logic [4:0]   tag_q [$];
    logic [W-1:0] d, prev_data, e;
    logic [SW-1:0] s;
    logic [1:0]   o;
    logic [4:0]   prev_tag, et;
    int sent, recvd;
    bit prev_stall, saw_full;
    sent = 0; recvd = 0; prev_stall = 0; saw_full = 0;
    prev_data = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 60 && recvd < 8; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 6 && cyc < 10);
      in_valid  = (sent < 8);
      d = $urandom; s = SW'($urandom); o = 2'($urandom);
      in_data = d; in_shamt = s; in_op = o; in_tag = 5'(sent);
      #1;
      assertions++;
      if (in_ready !== ((exp_q.size() < SW) || out_ready)) begin
        failures++; $display("[TB] FAIL stall_in_ready cyc=%0d actual=%b held=%0d", cyc, in_ready, exp_q.size());
      end
      if (!in_ready) saw_full = 1;
      if (prev_stall) begin
        assertions++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag) begin
          failures++; $display("[TB] FAIL stall_hold actual=%b/%h/%h required=1/%h/%h",
                               out_valid, out_data, out_tag, prev_data, prev_tag);
        end
      end
      if (out_valid && out_ready) begin
        assertions++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL stall_spurious actual=tag %h required=none", out_tag);
        end else begin
          e = exp_q.pop_front(); et = tag_q.pop_front();
          if (out_data !== e || out_tag !== et || out_tag !== 5'(recvd)) begin
            failures++; $display("[TB] FAIL stall_result actual=%h/%h required=%h/%h", out_data, out_tag, e, et);
          end
        end
        recvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(d, int'(s), o));
        tag_q.push_back(5'(sent));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    assertions++;
    if (recvd !== 8 || exp_q.size() !== 0) begin
      failures++; $display("[TB] FAIL stall_count actual=%0d required=8", recvd);
    end
    assertions++;
    if (!saw_full) begin failures++; $display("[TB] FAIL stall_backpressure actual=never required=in_ready low"); end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q [$];
    logic [4:0]   tag_q [$];
    logic [W-1:0] d, e;
    logic [SW-1:0] s;
    logic [1:0]   o;
    logic [4:0]   et;
    int sent, recvd, errs;
    sent = 0; recvd = 0; errs = 0;
    for (int cyc = 0; cyc < 60000 && recvd < 10000; cyc++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(3, 0) != 0);
      in_valid  = (sent < 10000) && ($urandom_range(3, 0) != 0);
      d = $urandom;
      if ($urandom_range(7, 0) == 0) d = {1'b1, 31'($urandom)};
      s = SW'($urandom); o = 2'($urandom);
      in_data = d; in_shamt = s; in_op = o; in_tag = 5'(sent);
      #1;
      assertions++;
      if (in_ready !== ((exp_q.size() < SW) || out_ready)) begin
        failures++; errs++;
        if (errs < 10) $display("[TB] FAIL rand_in_ready cyc=%0d actual=%b held=%0d", cyc, in_ready, exp_q.size());
      end
      if (out_valid && out_ready) begin
        assertions++;
        if (exp_q.size() == 0) begin
          failures++; errs++;
          if (errs < 10) $display("[TB] FAIL rand_spurious actual=tag %h required=none", out_tag);
        end else begin
          e = exp_q.pop_front(); et = tag_q.pop_front();
          if (out_data !== e || out_tag !== et) begin
            failures++; errs++;
            if (errs < 10) $display("[TB] FAIL rand_result actual=%h/%h required=%h/%h", out_data, out_tag, e, et);
          end
        end
        recvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(d, int'(s), o));
        tag_q.push_back(5'(sent));
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    assertions++;
    if (recvd !== 10000 || exp_q.size() !== 0) begin
      failures++; $display("[TB] FAIL rand_count actual=%0d required=10000", recvd);
    end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] res;
    logic [4:0]   rtag;
    int           lat, waited;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_shamt = SW'(i + 1); in_op = 2'b00; in_tag = 5'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    assertions++;
    if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL midreset_setup actual=%b required=1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL midreset_async actual=%b/%b required=0/1", out_valid, in_ready);
    end
    assertions++;
    if (out_data !== 32'h0 || out_tag !== 5'h0) begin
      failures++; $display("[TB] FAIL midreset_fields actual=%h/%h required=0/0", out_data, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      assertions++;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_stale cyc=%0d actual=%b required=0", i, out_valid); end
    end
    issue_and_wait(32'h0000F00D, 5'd8, 2'b00, 5'h15, res, rtag, lat);
    assertions++;
    if (lat !== SW || res !== 32'h00F00D00 || rtag !== 5'h15) begin
      failures++; $display("[TB] FAIL midreset_recover actual=%0d/%h/%h required=%0d/00f00d00/15", lat, res, rtag, SW);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
